// File: rtl/vga_scanout.sv
// VGA 640x480@60 timing and framebuffer scanout: 2x2 pixel scaling, 2-strobe pipeline, 16-entry palette.
// Define PALETTE_WR_EN to make the palette writable through pal_we/pal_idx/pal_rgb.
module vga_scanout #(
   parameter int FB_WIDTH  = 320,
   parameter int FB_HEIGHT = 240,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pix_stb,
   output logic [18:0] fb_addr,
   input  logic [3:0]  fb_data,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
`ifdef PALETTE_WR_EN
   input  logic        pal_we,
   input  logic [3:0]  pal_idx,
   input  logic [11:0] pal_rgb,
`endif
   output logic        frame_start
);

   localparam int H_ACTIVE = 2 * FB_WIDTH;
   localparam int V_ACTIVE = 2 * FB_HEIGHT;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW       = $clog2(H_TOTAL);
   localparam int VW       = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ONE        = HW'(1);
   localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ONE        = VW'(1);
   localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ROW_LAST   = VW'(V_ACTIVE - 1);
   localparam logic [18:0]   ROW_STEP     = 19'(FB_WIDTH);

   function automatic logic [11:0] default_rgb(input logic [3:0] idx);
      case (idx)
         4'h0:    default_rgb = 12'h000;
         4'h1:    default_rgb = 12'hFFF;
         4'h2:    default_rgb = 12'hF00;
         4'h3:    default_rgb = 12'h0F0;
         4'h4:    default_rgb = 12'h00F;
         4'h5:    default_rgb = 12'h4AF;
         4'h6:    default_rgb = 12'hFF0;
         4'h7:    default_rgb = 12'hF0F;
         4'h8:    default_rgb = 12'h0FF;
         4'h9:    default_rgb = 12'h888;
         4'hA:    default_rgb = 12'h444;
         4'hB:    default_rgb = 12'h2A2;
         4'hC:    default_rgb = 12'hF80;
         4'hD:    default_rgb = 12'h840;
         4'hE:    default_rgb = 12'hCCC;
         4'hF:    default_rgb = 12'h222;
         default: default_rgb = 12'h000;
      endcase
   endfunction

   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic [18:0]   row_base_q, row_base_d;
   logic [18:0]   fb_addr_q, addr_s;
   logic          active_s, hs_s, vs_s, line_end_s, frame_end_s;
   logic          act0_q, hs0_q, vs0_q;
   logic          act1_q, hs1_q, vs1_q;
   logic [3:0]    idx1_q;
   logic          hsync_q, vsync_q, frame_start_q;
   logic [11:0]   rgb_q, lookup_s;

   // Position decode: active window, sync windows and the read address for this position.
   always_comb begin
      active_s    = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
      hs_s        = ~((h_cnt_q >= H_SYNC_FIRST) && (h_cnt_q <= H_SYNC_LAST));
      vs_s        = ~((v_cnt_q >= V_SYNC_FIRST) && (v_cnt_q <= V_SYNC_LAST));
      line_end_s  = (h_cnt_q == H_LAST);
      frame_end_s = line_end_s && (v_cnt_q == V_LAST);
      if (active_s) begin
         addr_s = row_base_q + 19'(h_cnt_q[HW-1:1]);
      end else begin
         addr_s = 19'd0;
      end
   end

   // Counter and row-base next state; the row base steps once per pair of lines (2x vertical scaling).
   always_comb begin
      h_cnt_d    = h_cnt_q;
      v_cnt_d    = v_cnt_q;
      row_base_d = row_base_q;
      if (pix_stb) begin
         if (line_end_s) begin
            h_cnt_d = {HW{1'b0}};
            if (frame_end_s) begin
               v_cnt_d    = {VW{1'b0}};
               row_base_d = 19'd0;
            end else if (v_cnt_q[0] && (v_cnt_q < V_ROW_LAST)) begin
               v_cnt_d    = v_cnt_q + V_ONE;
               row_base_d = row_base_q + ROW_STEP;
            end else begin
               v_cnt_d    = v_cnt_q + V_ONE;
               row_base_d = row_base_q;
            end
         end else begin
            h_cnt_d = h_cnt_q + H_ONE;
         end
      end else begin
         h_cnt_d = h_cnt_q;
      end
   end

`ifdef PALETTE_WR_EN
   logic [11:0] pal_q [16];

   // Writable palette; reset reloads the default table and wins over a simultaneous write.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            pal_q[i] <= default_rgb(4'(i));
         end
      end else if (pal_we) begin
         pal_q[pal_idx] <= pal_rgb;
      end
   end

   assign lookup_s = pal_q[idx1_q];
`else
   assign lookup_s = default_rgb(idx1_q);
`endif

   // Counters plus the three pipeline stages; everything but frame_start moves only on pix_stb.
   always_ff @(posedge clock) begin
      if (reset) begin
         h_cnt_q       <= {HW{1'b0}};
         v_cnt_q       <= {VW{1'b0}};
         row_base_q    <= 19'd0;
         fb_addr_q     <= 19'd0;
         act0_q        <= 1'b0;
         hs0_q         <= 1'b1;
         vs0_q         <= 1'b1;
         act1_q        <= 1'b0;
         hs1_q         <= 1'b1;
         vs1_q         <= 1'b1;
         idx1_q        <= 4'h0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         rgb_q         <= 12'h000;
         frame_start_q <= 1'b0;
      end else begin
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         row_base_q    <= row_base_d;
         frame_start_q <= pix_stb && frame_end_s;
         if (pix_stb) begin
            fb_addr_q <= addr_s;
            act0_q    <= active_s;
            hs0_q     <= hs_s;
            vs0_q     <= vs_s;
            // BRAM data for fb_addr_q has settled because strobes are at least two clocks apart.
            idx1_q    <= fb_data;
            act1_q    <= act0_q;
            hs1_q     <= hs0_q;
            vs1_q     <= vs0_q;
            hsync_q   <= hs1_q;
            vsync_q   <= vs1_q;
            rgb_q     <= act1_q ? lookup_s : 12'h000;
         end
      end
   end

   assign fb_addr     = fb_addr_q;
   assign vga_hsync   = hsync_q;
   assign vga_vsync   = vsync_q;
   assign vga_r       = rgb_q[11:8];
   assign vga_g       = rgb_q[7:4];
   assign vga_b       = rgb_q[3:0];
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Randomized bench for vga_scanout on a scaled-down raster; a position-arithmetic reference model
// predicts fb_addr, syncs, rgb and frame_start on every clock.
module tb_vga_scanout;

   localparam int FBW   = 20;
   localparam int FBH   = 12;
   localparam int HFP   = 4;
   localparam int HSY   = 6;
   localparam int HBP   = 6;
   localparam int VFP   = 2;
   localparam int VSY   = 2;
   localparam int VBP   = 3;
   localparam int HACT  = 2 * FBW;
   localparam int VACT  = 2 * FBH;
   localparam int HT    = HACT + HFP + HSY + HBP;
   localparam int VT    = VACT + VFP + VSY + VBP;
   localparam int FRAME = HT * VT;
   localparam int NPIX  = FBW * FBH;

   localparam logic [11:0] DEF_PAL [16] = '{
      12'h000, 12'hFFF, 12'hF00, 12'h0F0, 12'h00F, 12'h4AF, 12'hFF0, 12'hF0F,
      12'h0FF, 12'h888, 12'h444, 12'h2A2, 12'hF80, 12'h840, 12'hCCC, 12'h222};

   logic        clock   = 1'b0;
   logic        reset   = 1'b1;
   logic        pix_stb = 1'b0;
   logic [18:0] fb_addr;
   logic [3:0]  fb_data = 4'h0;
   logic        vga_hsync, vga_vsync, frame_start;
   logic [3:0]  vga_r, vga_g, vga_b;
`ifdef PALETTE_WR_EN
   logic        pal_we  = 1'b0;
   logic [3:0]  pal_idx = 4'h0;
   logic [11:0] pal_rgb = 12'h000;
`endif

   vga_scanout #(
      .FB_WIDTH(FBW), .FB_HEIGHT(FBH),
      .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .pix_stb    (pix_stb),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .vga_hsync  (vga_hsync),
      .vga_vsync  (vga_vsync),
      .vga_r      (vga_r),
      .vga_g      (vga_g),
      .vga_b      (vga_b),
`ifdef PALETTE_WR_EN
      .pal_we     (pal_we),
      .pal_idx    (pal_idx),
      .pal_rgb    (pal_rgb),
`endif
      .frame_start(frame_start)
   );

   always #5 clock = ~clock;

   // Framebuffer BRAM model: one clock read latency.
   logic [3:0] mem [NPIX];
   always @(posedge clock) fb_data <= (fb_addr < 19'(NPIX)) ? mem[fb_addr] : 4'h0;

   typedef struct packed {
      logic       act;
      logic       hs;
      logic       vs;
      logic [3:0] idx;
   } pix_t;

   pix_t        pipe_q [$];
   logic [11:0] pal_m [16];
   int          checks   = 0;
   int          failures = 0;
   int          s        = 0;
   int          stb_total = 0;
   int          fs_last  = 0;
   bit          fs_seen  = 1'b0;
   bit          count_en = 1'b0;
   bit          rand_mem = 1'b0;
   int          nz_count = 0;
   int          exp_addr = 0;
   logic        exp_hs = 1'b1, exp_vs = 1'b1, exp_fs = 1'b0;
   logic [11:0] exp_rgb = 12'h000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at strobe %0d: got=%0h expected=%0h", tag, s, got, exp);
      end
   endtask

   task automatic fill_mem(input int lo, input int hi);
      for (int i = 0; i < NPIX; i++) mem[i] = 4'($urandom_range(hi, lo));
   endtask

   // Reference model: after each edge, derive expectations from the raster position of each strobe.
   task automatic model_update(input logic stb, input logic rst);
      int   p, h, v, a;
      pix_t e;
      exp_fs = 1'b0;
      if (rst) begin
         s = 0;
         pipe_q.delete();
         exp_addr = 0;
         exp_hs   = 1'b1;
         exp_vs   = 1'b1;
         exp_rgb  = 12'h000;
         fs_seen  = 1'b0;
         for (int i = 0; i < 16; i++) pal_m[i] = DEF_PAL[i];
      end else begin
         if (stb) begin
            p = s % FRAME;
            h = p % HT;
            v = p / HT;
            e.act = (h < HACT) && (v < VACT);
            e.hs  = !((h >= HACT + HFP) && (h < HACT + HFP + HSY));
            e.vs  = !((v >= VACT + VFP) && (v < VACT + VFP + VSY));
            a     = e.act ? (v / 2) * FBW + h / 2 : 0;
            e.idx = mem[a];
            exp_addr = a;
            pipe_q.push_back(e);
            if (pipe_q.size() > 2) begin
               e       = pipe_q.pop_front();
               exp_hs  = e.hs;
               exp_vs  = e.vs;
               exp_rgb = e.act ? pal_m[e.idx] : 12'h000;
            end
            exp_fs = (p == FRAME - 1);
            s++;
            stb_total++;
         end
`ifdef PALETTE_WR_EN
         if (pal_we) pal_m[pal_idx] = pal_rgb;
`endif
      end
   endtask

   task automatic step(input logic stb, input logic rst);
      pix_stb = stb;
      reset   = rst;
      @(posedge clock);
      #1;
      model_update(stb, rst);
      check("fb_addr", 32'(fb_addr), 32'(exp_addr));
      check("hsync", 32'(vga_hsync), 32'(exp_hs));
      check("vsync", 32'(vga_vsync), 32'(exp_vs));
      check("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
      check("frame_start", 32'(frame_start), 32'(exp_fs));
      if (count_en && stb && !rst && ({vga_r, vga_g, vga_b} != 12'h000)) nz_count++;
      if (frame_start) begin
         if (fs_seen) check("frame_period", 32'(stb_total - fs_last), 32'(FRAME));
         fs_seen = 1'b1;
         fs_last = stb_total;
      end
      pix_stb = 1'b0;
      reset   = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b0);
         if (exp_fs && rand_mem) fill_mem(0, 15);
         repeat ($urandom_range(4, 1)) step(1'b0, 1'b0);
      end
   endtask

   initial begin
      for (int i = 0; i < NPIX; i++) mem[i] = 4'h5;
      for (int i = 0; i < 16; i++) pal_m[i] = DEF_PAL[i];
      repeat (3) step(1'b0, 1'b1);
      step(1'b0, 1'b0);

      // Constant sky colour: every active pixel is 4AF, blanking is black.
      count_en = 1'b1;
      run(FRAME);
      count_en = 1'b0;
      check("nonzero_pixels", 32'(nz_count), 32'(HACT * VACT));

      fill_mem(0, 15);
      rand_mem = 1'b1;
      run(FRAME);

      // Mid-line, mid-frame reset coinciding with a strobe.
      run(10 * HT + 30);
      step(1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0);
      fill_mem(4, 6);

`ifdef PALETTE_WR_EN
      run(150);
      pal_we  = 1'b1;
      pal_idx = 4'h5;
      pal_rgb = 12'h123;
      step(1'b1, 1'b0);
      pal_we  = 1'b0;
      step(1'b0, 1'b0);
      run(200);
      pal_we  = 1'b1;
      pal_idx = 4'h5;
      pal_rgb = 12'h777;
      step(1'b0, 1'b1);
      pal_we  = 1'b0;
      step(1'b0, 1'b0);
      run(200);
`endif

      run(2 * FRAME + 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
